// File: rtl/core_seq_ctrl_pkg.sv
// Shared types and default constants for the multi-cycle core sequencer.
// Imported by the sequencer top and its wait timer.
package core_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        TRAP
    } seq_state_e;

    typedef enum logic [1:0] {
        TC_NONE    = 2'd0,
        TC_ILLEGAL = 2'd1,
        TC_IMEM    = 2'd2,
        TC_DMEM    = 2'd3
    } trap_cause_e;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W_DEFAULT   = 64;

endpackage

// File: rtl/core_seq_ctrl_wait_timer.sv
// Loadable up-counter that measures how long a bus request has gone unacknowledged.
// term_o is raised on the LIMIT-th waiting cycle; the counter holds there until cleared.
module seq_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic term_o
);

    localparam int           W    = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !term_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == LAST);

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath.
// Drives imem/dmem handshakes, gates IR/PC/RegisterFile writes, and reports halt, trap and counters.
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_ebreak,
    input  logic             inst_not_ipl,
    output logic             ir_we,
    output logic             rf_wen,
    output logic             pc_we,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    seq_state_e       state_q, state_d;
    trap_cause_e      cause_q, cause_d;
    logic [CNT_W-1:0] cycle_q, instret_q;
    logic             wait_clear, wait_en, wait_term;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_wen   = 1'b0;
        pc_we    = 1'b0;
        halted   = 1'b0;
        trap     = 1'b0;
        wait_en  = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else begin
                    wait_en = 1'b1;
                    if (wait_term) begin
                        state_d = TRAP;
                        cause_d = TC_IMEM;
                    end
                end
            end
            DECODE: begin
                if (inst_not_ipl) begin
                    state_d = TRAP;
                    cause_d = TC_ILLEGAL;
                end else if (is_ebreak) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = (is_load || is_store) ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    state_d = WB;
                end else begin
                    wait_en = 1'b1;
                    if (wait_term) begin
                        state_d = TRAP;
                        cause_d = TC_DMEM;
                    end
                end
            end
            WB: begin
                rf_wen  = !is_store;
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            HALT:    halted = 1'b1;
            TRAP:    trap   = 1'b1;
            default: state_d = FETCH;
        endcase

        // The reset state is FETCH, so its request and IR write must be masked while reset is held.
        if (!rst) begin
            imem_req = 1'b0;
            ir_we    = 1'b0;
        end
    end

    // The wait counter restarts whenever the sequencer moves to a new state.
    assign wait_clear = (state_d != state_q);

    seq_wait_timer #(
        .LIMIT(TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst),
        .clear_i(wait_clear),
        .en_i   (wait_en),
        .term_o (wait_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            cause_q   <= TC_NONE;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q != HALT && state_q != TRAP) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (state_q == WB) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign trap_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule
